seq_bit_serializer: RTL and testbench

- Upstream stage for the Mealy sequence detector. Converts parallel words into the serial bit stream `x` that the detector samples once per clock.
- A valid/ready load port feeds a shift register, backed by one holding register. Back-to-back words stream with no idle gap.
- Gives the detector, and its benches, a word-oriented source instead of hand-timed bit pokes.

---
 rtl/seq_pkg.sv | 19 +
 rtl/word_hold_reg.sv | 42 ++++
 rtl/seq_bit_serializer.sv | 106 ++++++++++
 tb/tb_seq_bit_serializer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants and state encodings for the bit serializer and the Mealy
// sequence detector it feeds.
package seq_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } ser_state_e;

  // Detector states for the overlapping "110" Mealy detector.
  typedef enum logic [1:0] {
    DetS0  = 2'd0,
    DetS1  = 2'd1,
    DetS11 = 2'd2
  } det_state_e;

endpackage

// File: rtl/word_hold_reg.sv
// Single-entry holding register with a full flag; a write takes precedence
// over a take in the same cycle.
module word_hold_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [Width-1:0] data_i,
  input  logic             take_i,
  output logic             full_o,
  output logic [Width-1:0] data_o
);

  logic             full_q, full_d;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (wr_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (take_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer: valid/ready load port, one holding register and a
// shift register that streams back-to-back words with no idle gap.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_start,
  output logic             busy
);

  localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d, shifted;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full, hold_wr, hold_take;
  logic             accept, last_bit;

  // Ready comes from registered state only, so a full hold blocks the edge
  // that frees it.
  assign load_ready = !hold_full;
  assign accept     = load_valid && load_ready;
  assign last_bit   = (state_q == StShift) && (cnt_q == LastCnt);
  assign hold_wr    = accept && (state_q == StShift) && !last_bit;
  assign hold_take  = last_bit && hold_full;

  word_hold_reg #(
    .Width (WIDTH)
  ) u_hold (
    .clk_i  (clock),
    .rst_ni (reset),
    .wr_i   (hold_wr),
    .data_i (data_in),
    .take_i (hold_take),
    .full_o (hold_full),
    .data_o (hold_data)
  );

  always_comb begin
    if (MSB_FIRST) begin
      shifted = {shift_q[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StShift;
          cnt_d   = '0;
          shift_d = data_in;
        end
      end
      StShift: begin
        cnt_d   = cnt_q + CntW'(1);
        shift_d = shifted;
        if (last_bit) begin
          cnt_d = '0;
          if (hold_full) begin
            shift_d = hold_data;
          end else if (accept) begin
            shift_d = data_in;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign x_valid    = (state_q == StShift);
  assign word_start = x_valid && (cnt_q == '0);
  assign busy       = x_valid || hold_full;
  assign x          = x_valid ? (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]) : IDLE_BIT;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench: MSB-first and LSB-first serializer instances checked against
// a bit-level scoreboard, plus a "110" Mealy detector on the MSB-first stream.
module tb_seq_bit_serializer;
  import seq_pkg::*;

  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] da = '0, db = '0;
  logic         va = 1'b0, vb = 1'b0;
  logic         ra, xa, xva, wsa, ba;
  logic         rb, xb, xvb, wsb, bb;

  always #5 clock = ~clock;

  seq_bit_serializer #(
    .WIDTH     (W),
    .MSB_FIRST (1'b1),
    .IDLE_BIT  (1'b0)
  ) u_msb (
    .clock      (clock),
    .reset      (reset),
    .data_in    (da),
    .load_valid (va),
    .load_ready (ra),
    .x          (xa),
    .x_valid    (xva),
    .word_start (wsa),
    .busy       (ba)
  );

  seq_bit_serializer #(
    .WIDTH     (W),
    .MSB_FIRST (1'b0),
    .IDLE_BIT  (1'b0)
  ) u_lsb (
    .clock      (clock),
    .reset      (reset),
    .data_in    (db),
    .load_valid (vb),
    .load_ready (rb),
    .x          (xb),
    .x_valid    (xvb),
    .word_start (wsb),
    .busy       (bb)
  );

  typedef struct packed {
    logic b;
    logic s;
  } exp_t;

  int         n_chk  = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  exp_t       qa[$];
  exp_t       qb[$];
  logic [2:0] hist = 3'b000;

  // Detector under integration, fed by the serializer's bit stream.
  det_state_e det_q;
  logic       det_z;

  always_comb begin
    det_z = 1'b0;
    if (xva && (det_q == DetS11) && !xa) det_z = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      det_q <= DetS0;
    end else if (xva) begin
      case (det_q)
        DetS0:   det_q <= xa ? DetS1 : DetS0;
        DetS1:   det_q <= xa ? DetS11 : DetS0;
        DetS11:  det_q <= xa ? DetS11 : DetS0;
        default: det_q <= DetS0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset && mon_en) begin
      check("a_x_valid", {31'd0, xva}, {31'd0, qa.size() != 0});
      if (xva && qa.size() != 0) begin
        e = qa.pop_front();
        check("a_x", {31'd0, xa}, {31'd0, e.b});
        check("a_word_start", {31'd0, wsa}, {31'd0, e.s});
        hist = {hist[1:0], e.b};
        check("det_z", {31'd0, det_z}, {31'd0, hist == 3'b110});
      end else if (!xva) begin
        check("a_idle_x", {31'd0, xa}, 32'd0);
        check("a_idle_ws", {31'd0, wsa}, 32'd0);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset && mon_en) begin
      check("b_x_valid", {31'd0, xvb}, {31'd0, qb.size() != 0});
      if (xvb && qb.size() != 0) begin
        e = qb.pop_front();
        check("b_x", {31'd0, xb}, {31'd0, e.b});
        check("b_word_start", {31'd0, wsb}, {31'd0, e.s});
      end
    end
  end

  // Offers a word until accepted; sel=1 targets the LSB-first instance.
  task automatic send(input bit sel, input logic [W-1:0] w, input bit keep, output int stalls);
    bit   acc;
    logic rdy;
    exp_t e;
    acc    = 1'b0;
    stalls = 0;
    if (sel) begin db = w; vb = 1'b1; end
    else     begin da = w; va = 1'b1; end
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clock);
      rdy = sel ? rb : ra;
      @(posedge clock);
      if (rdy) begin
        acc = 1'b1;
        for (int k = 0; k < W; k++) begin
          e.b = sel ? w[k] : w[W-1-k];
          e.s = (k == 0);
          if (sel) qb.push_back(e);
          else     qa.push_back(e);
        end
      end else begin
        stalls++;
      end
    end
    #1;
    if (!keep) begin
      if (sel) vb = 1'b0;
      else     va = 1'b0;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clock);
      done = (qa.size() == 0) && (qb.size() == 0);
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    #1;
    check("busy_a_after", {31'd0, ba}, 32'd0);
    check("busy_b_after", {31'd0, bb}, 32'd0);
    check("xvalid_a_after", {31'd0, xva}, 32'd0);
    check("x_a_after", {31'd0, xa}, 32'd0);
    check("ready_a_after", {31'd0, ra}, 32'd1);
  endtask

  initial begin
    int st;
    #1;
    check("rst_ready", {31'd0, ra}, 32'd1);
    check("rst_x_valid", {31'd0, xva}, 32'd0);
    check("rst_word_start", {31'd0, wsa}, 32'd0);
    check("rst_busy", {31'd0, ba}, 32'd0);
    check("rst_x", {31'd0, xa}, 32'd0);
    #20 reset = 1'b1;
    mon_en = 1'b1;
    repeat (7) @(posedge clock);
    #1;

    // Single word
    send(1'b0, 8'b1110_0111, 1'b0, st);
    drain();

    // Back-to-back: second word goes to the hold register
    send(1'b0, 8'hE7, 1'b1, st);
    send(1'b0, 8'h33, 1'b0, st);
    check("b2b_stalls", st, 32'd0);
    check("b2b_ready_low", {31'd0, ra}, 32'd0);
    check("b2b_busy", {31'd0, ba}, 32'd1);
    drain();

    // Backpressure: valid held high across three words
    send(1'b0, 8'h5A, 1'b1, st);
    send(1'b0, 8'hC3, 1'b1, st);
    check("bp_w2_stalls", st, 32'd0);
    send(1'b0, 8'h96, 1'b0, st);
    check("bp_w3_stalls", st, W - 1);
    drain();

    // LSB-first
    send(1'b1, 8'b0000_0011, 1'b0, st);
    drain();

    // Reset mid-word with a word held
    send(1'b0, 8'hE7, 1'b1, st);
    send(1'b0, 8'h33, 1'b0, st);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    qa.delete();
    hist = 3'b000;
    #1;
    check("mid_rst_x", {31'd0, xa}, 32'd0);
    check("mid_rst_x_valid", {31'd0, xva}, 32'd0);
    check("mid_rst_busy", {31'd0, ba}, 32'd0);
    check("mid_rst_ready", {31'd0, ra}, 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    send(1'b0, 8'hA5, 1'b0, st);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
